// File: rtl/reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// reset_seq_pkg
// Shared definitions for the reset sequencer:
//   - state_e    : sequencer state encoding (3 bits)
//   - CNT_W      : default width of the shared cycle counter
//   - IDX_W      : width of the reported failing-domain index (up to 8 domains)
//   - lowest_set : index of the lowest set bit of a (1<<IDX_W)-bit vector
// ---------------------------------------------------------------------------
package reset_seq_pkg;

   localparam int CNT_W = 8;
   localparam int IDX_W = 3;

   typedef enum logic [2:0] {
      HOLD    = 3'd0,
      RELEASE = 3'd1,
      WAIT    = 3'd2,
      GAP     = 3'd3,
      DONE    = 3'd4,
      ERROR   = 3'd5
   } state_e;

   // Scanning from the top down lets the last hit be the lowest index.
   // Returns 0 for an all-zero vector; callers only use it when a bit is set.
   function automatic logic [IDX_W-1:0] lowest_set(input logic [(1<<IDX_W)-1:0] vec);
      logic [IDX_W-1:0] res;
      res = '0;
      for (int i = (1 << IDX_W) - 1; i >= 0; i--) begin
         if (vec[i]) begin
            res = IDX_W'(i);
         end
      end
      return res;
   endfunction

endpackage : reset_seq_pkg

// File: rtl/reset_seq_timer.sv
// ---------------------------------------------------------------------------
// reset_seq_timer
// Clearable up-counter with a terminal-count compare. The count saturates at
// all-ones instead of wrapping, so a stalled state can never alias back to an
// early count.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset (count -> 0)
//   clr_i     : clear count to 0 on the next edge (has priority over en_i)
//   en_i      : advance the count by one
//   tc_val_i  : terminal-count value to compare against
//   tc_o      : high while the current count equals tc_val_i
// ---------------------------------------------------------------------------
module reset_seq_timer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] tc_val_i,
   output logic             tc_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tc_o = (cnt_q == tc_val_i);

endmodule : reset_seq_timer

// File: rtl/reset_sequencer.sv
// ---------------------------------------------------------------------------
// reset_sequencer
// Releases N_DOM downstream reset domains one at a time in index order. After
// an initial hold, each domain is released, its synchronized ready is awaited
// (with timeout), and a gap is inserted before the next domain. Once all are
// up, any ready loss is trapped as an error and all domains are reasserted.
//   clk_A         : clock
//   rst_in        : synchronous active-high reset, overrides everything
//   soft_rst_req  : one-cycle pulse, reassert all domains and restart
//   rdy_in        : per-domain ready, already in the clk_A domain
//   dom_rst_n_out : per-domain active-low reset (registered)
//   all_done      : all domains released and ready
//   busy          : sequencing in progress (HOLD/RELEASE/WAIT/GAP)
//   err           : sticky timeout / ready-loss flag
//   err_idx       : index of the failing domain
// ---------------------------------------------------------------------------
module reset_sequencer #(
   parameter int N_DOM       = 3,
   parameter int HOLD_CYC    = 16,
   parameter int GAP_CYC     = 4,
   parameter int TIMEOUT_CYC = 64,
   parameter int CNT_W       = 8
) (
   input  logic                           clk_A,
   input  logic                           rst_in,
   input  logic                           soft_rst_req,
   input  logic [N_DOM-1:0]               rdy_in,
   output logic [N_DOM-1:0]               dom_rst_n_out,
   output logic                           all_done,
   output logic                           busy,
   output logic                           err,
   output logic [reset_seq_pkg::IDX_W-1:0] err_idx
);

   import reset_seq_pkg::*;

   localparam int DOM_IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
   localparam logic [DOM_IDX_W-1:0] LAST_IDX = DOM_IDX_W'(N_DOM - 1);

   // Terminal counts are "cycles - 1" because the counter reads 0 on the
   // first cycle of each state.
   localparam logic [CNT_W-1:0] HOLD_TC    = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_TC     = CNT_W'(GAP_CYC - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_TC = CNT_W'(TIMEOUT_CYC - 1);

   state_e                 state_q,     state_d;
   logic [DOM_IDX_W-1:0]   idx_q,       idx_d;
   logic [N_DOM-1:0]       dom_rst_n_q, dom_rst_n_d;
   logic                   all_done_q,  all_done_d;
   logic                   busy_q,      busy_d;
   logic                   err_q,       err_d;
   logic [IDX_W-1:0]       err_idx_q,   err_idx_d;

   logic                   cnt_clr;
   logic                   cnt_en;
   logic                   cnt_tc;
   logic [CNT_W-1:0]       tc_val;
   logic [(1<<IDX_W)-1:0]  lost_vec;

   // ------------------------------------------------------------------
   // Shared cycle counter
   // ------------------------------------------------------------------
   reset_seq_timer #(
      .WIDTH    (CNT_W)
   ) u_timer (
      .clk_i    (clk_A),
      .rst_i    (rst_in),
      .clr_i    (cnt_clr),
      .en_i     (cnt_en),
      .tc_val_i (tc_val),
      .tc_o     (cnt_tc)
   );

   always_comb begin
      tc_val = '0;
      cnt_en = 1'b0;
      unique case (state_q)
         HOLD: begin
            tc_val = HOLD_TC;
            cnt_en = 1'b1;
         end
         GAP: begin
            tc_val = GAP_TC;
            cnt_en = 1'b1;
         end
         WAIT: begin
            tc_val = TIMEOUT_TC;
            cnt_en = 1'b1;
         end
         default: begin
            tc_val = '0;
            cnt_en = 1'b0;
         end
      endcase
   end

   // Dropped ready bits, widened to the helper's fixed width.
   always_comb begin
      lost_vec              = '0;
      lost_vec[N_DOM-1:0]   = ~rdy_in;
   end

   // ------------------------------------------------------------------
   // Next-state and registered-output logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      dom_rst_n_d = dom_rst_n_q;
      err_d       = err_q;
      err_idx_d   = err_idx_q;
      all_done_d  = 1'b0;
      busy_d      = 1'b1;

      if (soft_rst_req) begin
         // Takes priority over every event seen in the same cycle.
         state_d     = HOLD;
         idx_d       = '0;
         dom_rst_n_d = '0;
         err_d       = 1'b0;
         err_idx_d   = '0;
      end else begin
         unique case (state_q)
            HOLD: begin
               if (cnt_tc) begin
                  state_d = RELEASE;
               end
            end
            RELEASE: begin
               // Reset is lifted on the edge into WAIT, so the first
               // WAIT cycle is also the first cycle the domain runs.
               state_d            = WAIT;
               dom_rst_n_d[idx_q] = 1'b1;
            end
            WAIT: begin
               // Ready is checked before timeout so a ready arriving on
               // the final allowed cycle still counts.
               if (rdy_in[idx_q]) begin
                  state_d = (idx_q == LAST_IDX) ? DONE : GAP;
               end else if (cnt_tc) begin
                  state_d   = ERROR;
                  err_idx_d = IDX_W'(idx_q);
               end
            end
            GAP: begin
               if (cnt_tc) begin
                  state_d = RELEASE;
                  idx_d   = idx_q + 1'b1;
               end
            end
            DONE: begin
               if (|lost_vec) begin
                  state_d   = ERROR;
                  err_idx_d = lowest_set(lost_vec);
               end
            end
            ERROR: begin
               state_d = ERROR;
            end
            default: begin
               state_d = ERROR;
            end
         endcase
      end

      // Output overrides depend on the state being entered so they line
      // up with the state register.
      unique case (state_d)
         DONE: begin
            all_done_d  = 1'b1;
            busy_d      = 1'b0;
            dom_rst_n_d = '1;
         end
         ERROR: begin
            err_d       = 1'b1;
            busy_d      = 1'b0;
            dom_rst_n_d = '0;
         end
         default: begin
            busy_d      = 1'b1;
         end
      endcase

      // Every state entry (including a HOLD restart) starts a fresh count.
      cnt_clr = soft_rst_req || (state_d != state_q);
   end

   always_ff @(posedge clk_A) begin
      if (rst_in) begin
         state_q     <= HOLD;
         idx_q       <= '0;
         dom_rst_n_q <= '0;
         all_done_q  <= 1'b0;
         busy_q      <= 1'b1;
         err_q       <= 1'b0;
         err_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         dom_rst_n_q <= dom_rst_n_d;
         all_done_q  <= all_done_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
         err_idx_q   <= err_idx_d;
      end
   end

   assign dom_rst_n_out = dom_rst_n_q;
   assign all_done      = all_done_q;
   assign busy          = busy_q;
   assign err           = err_q;
   assign err_idx       = err_idx_q;

endmodule : reset_sequencer

// File: tb/tb_reset_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reset_sequencer
// Cycle-numbered scenarios for reset_sequencer (N_DOM=3, HOLD=16, GAP=4,
// TIMEOUT=64). Expected output values are queued with the cycle at which
// they must appear and compared when the run reaches that cycle. Each
// domain's ready is a 3-FF synchronizer of its reset output, with a per-bit
// force-low mask to model stuck or dropped readies.
// ---------------------------------------------------------------------------
module tb_reset_sequencer;

   localparam int N_DOM = 3;

   logic             clk_A = 1'b0;
   logic             rst_in = 1'b1;
   logic             soft_rst_req = 1'b0;
   logic [N_DOM-1:0] rdy_in;
   logic [N_DOM-1:0] dom_rst_n_out;
   logic             all_done;
   logic             busy;
   logic             err;
   logic [2:0]       err_idx;

   reset_sequencer #(
      .N_DOM        (N_DOM),
      .HOLD_CYC     (16),
      .GAP_CYC      (4),
      .TIMEOUT_CYC  (64),
      .CNT_W        (8)
   ) dut (
      .clk_A         (clk_A),
      .rst_in        (rst_in),
      .soft_rst_req  (soft_rst_req),
      .rdy_in        (rdy_in),
      .dom_rst_n_out (dom_rst_n_out),
      .all_done      (all_done),
      .busy          (busy),
      .err           (err),
      .err_idx       (err_idx)
   );

   always #5 clk_A = ~clk_A;

   // Domain-side ready model
   logic [N_DOM-1:0] sync1 = '0;
   logic [N_DOM-1:0] sync2 = '0;
   logic [N_DOM-1:0] sync3 = '0;
   logic [N_DOM-1:0] force_low = '0;

   always @(posedge clk_A) begin
      sync1 <= dom_rst_n_out;
      sync2 <= sync1;
      sync3 <= sync2;
   end

   assign rdy_in = sync3 & ~force_low;

   // Scoreboard
   localparam int K_RSTN = 0;
   localparam int K_DONE = 1;
   localparam int K_BUSY = 2;
   localparam int K_ERR  = 3;
   localparam int K_EIDX = 4;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_pass = 0;

   task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
      end else begin
         n_pass++;
         $display("check %s cyc %0d: %0h ok", tag, cyc, got);
      end
   endtask

   task automatic push_one(input int c, input int k, input int v);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.val  = 8'(v);
      sb_q.push_back(e);
   endtask

   task automatic push_state(input int c, input int rstn, input int done,
                             input int bsy, input int er, input int eidx);
      push_one(c, K_RSTN, rstn);
      push_one(c, K_DONE, done);
      push_one(c, K_BUSY, bsy);
      push_one(c, K_ERR,  er);
      push_one(c, K_EIDX, eidx);
   endtask

   // Compare every queued item due at the current cycle, mid-cycle.
   task automatic check_due();
      exp_t e;
      @(negedge clk_A);
      while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
         e = sb_q.pop_front();
         case (e.kind)
            K_RSTN:  check_val("dom_rst_n", 8'(dom_rst_n_out), e.val);
            K_DONE:  check_val("all_done",  8'(all_done),      e.val);
            K_BUSY:  check_val("busy",      8'(busy),          e.val);
            K_ERR:   check_val("err",       8'(err),           e.val);
            default: check_val("err_idx",   8'(err_idx),       e.val);
         endcase
      end
   endtask

   task automatic step();
      @(posedge clk_A);
      #1;
      cyc++;
   endtask

   task automatic run_until(input int c);
      while (cyc < c) begin
         check_due();
         step();
      end
   endtask

   // Hold reset for a few edges; cycle 0 follows the last edge with rst_in=1.
   task automatic start_seq();
      rst_in = 1'b1;
      soft_rst_req = 1'b0;
      repeat (3) @(posedge clk_A);
      #1;
      rst_in = 1'b0;
      cyc = 0;
   endtask

   task automatic soft_pulse_at(input int c);
      run_until(c);
      soft_rst_req = 1'b1;
      check_due();
      step();
      soft_rst_req = 1'b0;
   endtask

   task automatic drain_check();
      check_val("sb_empty", 8'(sb_q.size()), 8'd0);
      sb_q.delete();
   endtask

   initial begin
      // ---------------- Nominal, soft re-sequence, ready loss ----------
      $display("scenario nominal");
      force_low = '0;
      start_seq();
      push_state(0,  3'b000, 0, 1, 0, 0);
      push_one(16, K_RSTN, 3'b000);
      push_one(17, K_RSTN, 3'b001);
      push_one(25, K_RSTN, 3'b001);
      push_one(26, K_RSTN, 3'b011);
      push_one(34, K_RSTN, 3'b011);
      push_one(35, K_RSTN, 3'b111);
      push_one(38, K_DONE, 0);
      push_one(38, K_BUSY, 1);
      push_state(39, 3'b111, 1, 0, 0, 0);
      push_state(100, 3'b111, 1, 0, 0, 0);
      // soft request at cycle 100
      push_state(101, 3'b000, 0, 1, 0, 0);
      push_one(117, K_RSTN, 3'b000);
      push_one(118, K_RSTN, 3'b001);
      push_one(139, K_DONE, 0);
      push_state(140, 3'b111, 1, 0, 0, 0);
      // ready[2:1] dropped during cycle 145
      push_state(145, 3'b111, 1, 0, 0, 0);
      push_state(146, 3'b000, 0, 0, 1, 1);
      push_state(160, 3'b000, 0, 0, 1, 1);
      soft_pulse_at(100);
      run_until(145);
      force_low = 3'b110;
      check_due();
      step();
      force_low = '0;
      run_until(161);
      drain_check();

      // ---------------- Ready timeout on domain 1 ----------------------
      $display("scenario timeout");
      force_low = 3'b010;
      start_seq();
      push_state(0,   3'b000, 0, 1, 0, 0);
      push_state(89,  3'b011, 0, 1, 0, 0);
      push_state(90,  3'b000, 0, 0, 1, 1);
      push_state(150, 3'b000, 0, 0, 1, 1);
      push_state(161, 3'b000, 0, 1, 0, 0);
      soft_pulse_at(160);
      run_until(162);
      drain_check();

      // ---------------- Ready rises on the timeout cycle ---------------
      $display("scenario ready_on_timeout");
      force_low = 3'b010;
      start_seq();
      push_state(89, 3'b011, 0, 1, 0, 0);
      push_state(90, 3'b011, 0, 1, 0, 0);
      push_one(94, K_RSTN, 3'b011);
      push_one(95, K_RSTN, 3'b111);
      push_one(98, K_DONE, 0);
      push_state(99, 3'b111, 1, 0, 0, 0);
      run_until(89);
      force_low = '0;
      run_until(100);
      drain_check();

      // ---------------- Soft request on the timeout cycle --------------
      $display("scenario soft_on_timeout");
      force_low = 3'b010;
      start_seq();
      push_state(89,  3'b011, 0, 1, 0, 0);
      push_state(90,  3'b000, 0, 1, 0, 0);
      push_one(106, K_RSTN, 3'b000);
      push_one(107, K_RSTN, 3'b001);
      push_one(120, K_ERR, 0);
      soft_pulse_at(89);
      run_until(121);
      drain_check();

      // ---------------- Reset during WAIT of domain 1 ------------------
      $display("scenario mid_reset");
      force_low = '0;
      start_seq();
      push_one(27, K_RSTN, 3'b011);
      push_one(27, K_BUSY, 1);
      run_until(27);
      rst_in = 1'b1;
      check_due();
      @(posedge clk_A);
      #1;
      rst_in = 1'b0;
      cyc = 0;
      push_state(0, 3'b000, 0, 1, 0, 0);
      push_one(16, K_RSTN, 3'b000);
      push_one(17, K_RSTN, 3'b001);
      push_one(26, K_RSTN, 3'b011);
      push_one(35, K_RSTN, 3'b111);
      push_state(39, 3'b111, 1, 0, 0, 0);
      run_until(40);
      drain_check();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_reset_sequencer

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences reset release across N_DOM downstream reset domains, in index order 0..N_DOM-1.
- Each domain's active-low reset output feeds that domain's 3-stage reset synchronizer (nrst_in).
- The synchronized ready returned by each domain gates release of the next domain.
- Provides a hold period, inter-domain gap, per-domain ready timeout with error capture, and a soft re-sequence request.

Parameters:
- N_DOM, 3, number of reset domains (2..8).
- HOLD_CYC, 16, cycles all domains are held in reset before the first release (>=1).
- GAP_CYC, 4, cycles between one domain's ready and the next domain's release (>=1).
- TIMEOUT_CYC, 64, maximum WAIT cycles allowed for a domain's ready (>=4).
- CNT_W, 8, shared counter width; must hold max(HOLD_CYC, GAP_CYC, TIMEOUT_CYC).

Ports:
- clk_A  in  1  single clock.
- rst_in  in  1  synchronous, active-high reset.
- soft_rst_req  in  1  single-cycle pulse: reassert all domains and restart the sequence.
- rdy_in  in  N_DOM  per-domain ready, already synchronized to clk_A.
- dom_rst_n_out  out  N_DOM  per-domain reset, active low, registered.
- all_done  out  1  high while all domains are released and ready.
- busy  out  1  high in HOLD, RELEASE, WAIT and GAP.
- err  out  1  sticky timeout/ready-loss flag.
- err_idx  out  3  index of the failing domain.

Behaviour:
- Interface (already decided): one clock; reset is synchronous and active-high; clock port clk_A, reset port rst_in.
- rst_in=1 at a clock edge sets: dom_rst_n_out=0 (all bits), all_done=0, busy=1, err=0, err_idx=0, idx=0, cnt=0, state=HOLD.
- rst_in overrides everything, including mid-sequence.
- All outputs are registered and change in the same cycle the state is entered.
- Cycle numbering: cycle 0 is the first cycle with rst_in=0.
- HOLD: occupies exactly HOLD_CYC cycles, then goes to RELEASE.
- RELEASE: lasts 1 cycle. Sets dom_rst_n_out[idx]=1 (stays set while sequencing), clears cnt, goes to WAIT.
  - First cycle with dom_rst_n_out[0]=1 is cycle HOLD_CYC+1.
- WAIT: samples rdy_in[idx] every cycle.
  - rdy_in[idx]=1 and idx=N_DOM-1: go to DONE.
  - rdy_in[idx]=1 and idx<N_DOM-1: go to GAP.
  - rdy_in[idx]=0 with cnt=TIMEOUT_CYC-1: go to ERROR with err_idx=idx. So ERROR is entered after exactly TIMEOUT_CYC WAIT cycles.
  - rdy_in[idx]=1 in the same cycle as the timeout: ready wins.
- GAP: occupies exactly GAP_CYC cycles, then idx increments and the state goes to RELEASE.
- rdy_in bits of domains not yet released are ignored.
- DONE: all_done=1, busy=0, all dom_rst_n_out=1.
  - Any rdy_in bit falling to 0 goes to ERROR, with err_idx = lowest dropped index.
- ERROR: err=1, all dom_rst_n_out=0, all_done=0, busy=0.
  - Held until soft_rst_req or rst_in.
- soft_rst_req=1 in any state (rst_in=0): next cycle matches the reset state.
  - Sequence restarts at HOLD; err and err_idx are cleared.
  - soft_rst_req takes priority over timeout, ready and ready-loss in the same cycle.
  - A second soft_rst_req during HOLD restarts the hold count.
- Counter: a single cnt, cleared on every state entry. It counts HOLD, GAP and WAIT cycles and never wraps.
- The index register is clog2(N_DOM) bits, zero-extended onto err_idx.

Decomposition:
- Package reset_seq_pkg holds:
  - state enum: HOLD, RELEASE, WAIT, GAP, DONE, ERROR (3-bit encoding);
  - CNT_W and IDX_W constants;
  - a function returning the lowest set index of a vector.
- One natural sub-module: reset_seq_timer, the loadable/clearable cycle counter with a terminal-count compare.
- FSM, index register and output registers stay in reset_sequencer.

Test Plan:
- Nominal sequence. Setup: N_DOM=3, HOLD=16, GAP=4, TIMEOUT=64; each rdy_in[k] modelled as a 3-FF synchronizer of dom_rst_n_out[k]; rst_in released.
  -> dom_rst_n_out[0] rises at cycle 17, [1] at cycle 26, [2] at cycle 35.
  -> all_done=1 from cycle 39; busy falls at cycle 39; err stays 0.
- Ready timeout: rdy_in[1] tied to 0.
  -> ERROR entered at cycle 90: err=1, err_idx=1, dom_rst_n_out=3'b000, all_done=0.
  -> Outputs hold until soft_rst_req.
- Soft re-sequence: after DONE, pulse soft_rst_req at cycle 100.
  -> Cycle 101: all resets 0, all_done=0, busy=1.
  -> dom_rst_n_out[0] rises at cycle 101+HOLD_CYC+1=118.
- Ready loss: in DONE, drop rdy_in[2] and rdy_in[1] together for 1 cycle.
  -> ERROR with err_idx=1; all domains reasserted next cycle.
- Simultaneous events:
  - rdy_in[idx] rises on the timeout cycle -> GAP, no error.
  - soft_rst_req on the timeout cycle -> HOLD with err=0.
- Mid-operation reset: assert rst_in during WAIT for domain 1.
  -> Next cycle: all outputs at reset values, idx=0; a full nominal sequence follows.
